std_div_seq: RTL and testbench

//   Sequential unsigned divider, restoring algorithm, one quotient bit per cycle.
//   - Computes left / right and left % right over WIDTH+1 cycles from start.
//   - Uses the go/done handshake of the group-controlled primitives.
//   - Results feed std_reg inputs: done drives the register write_en, outputs drive in.

---
 rtl/std_div_seq.sv | 96 +++++++++
 tb/tb_std_div_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/std_div_seq.sv
// Sequential unsigned restoring divider: one quotient bit per cycle, go/done handshake.
// The dividend register doubles as the quotient register; quotient bits shift in as dividend bits shift out.
module std_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out_quotient,
  output logic [WIDTH-1:0] out_remainder,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] dvd_quo;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] rem;
  logic [CW-1:0]    iter;

  logic [WIDTH:0]   rem_shift;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic             fits;
  logic             last_step;

  // rem_shift keeps the bit shifted out of rem so a large remainder is never truncated
  always_comb begin
    rem_shift = {rem, dvd_quo[WIDTH-1]};
    fits      = rem_shift >= {1'b0, divisor};
    rem_sub   = rem_shift[WIDTH-1:0] - divisor;
    rem_next  = fits ? rem_sub : rem_shift[WIDTH-1:0];
    quo_next  = {dvd_quo[WIDTH-2:0], fits};
    last_step = (iter == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = 1'b0;
    case (state)
      IDLE: if (go) state_next = RUN;
      RUN:  if (last_step) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dvd_quo       <= '0;
      divisor       <= '0;
      rem           <= '0;
      iter          <= '0;
      out_quotient  <= '0;
      out_remainder <= '0;
    end else begin
      case (state)
        IDLE: if (go) begin
          dvd_quo <= left;
          divisor <= right;
          rem     <= '0;
          iter    <= '0;
        end
        RUN: begin
          dvd_quo <= quo_next;
          rem     <= rem_next;
          iter    <= iter + CW'(1);
          if (last_step) begin
            out_quotient  <= quo_next;
            out_remainder <= rem_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_std_div_seq.sv
// Randomized bench for std_div_seq: WIDTH=32 and WIDTH=4 instances checked every cycle
// against an arithmetic reference model, plus literal expectations for the documented cases.
module tb_std_div_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        go32 = 1'b0, go4 = 1'b0;
  logic [31:0] left32 = '0, right32 = '0, q32, r32;
  logic [3:0]  left4 = '0, right4 = '0, q4, r4;
  logic        done32, done4;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  std_div_seq #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .go(go32), .left(left32), .right(right32),
    .out_quotient(q32), .out_remainder(r32), .done(done32)
  );

  std_div_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .go(go4), .left(left4), .right(right4),
    .out_quotient(q4), .out_remainder(r4), .done(done4)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: an accepted op finishes W+1 cycles later; the next op may start
  // one cycle after that. Results are plain division, with the divide-by-zero convention.
  longint cyc = 0;
  bit     active [2];
  longint st [2];
  longint pq [2], pr [2], eq [2], er [2];
  bit     ed [2];

  function automatic void ref_div(input int w, input longint l, input longint r,
                                  output longint q, output longint rm);
    if (r == 0) begin
      q  = (longint'(1) << w) - 1;
      rm = l;
    end else begin
      q  = l / r;
      rm = l % r;
    end
  endfunction

  task automatic model_step(input int i, input bit g, input longint l, input longint r,
                            input int w);
    if (reset) begin
      active[i] = 1'b0;
      eq[i] = 0;
      er[i] = 0;
      ed[i] = 1'b0;
    end else begin
      if (g && (!active[i] || cyc >= st[i] + w + 2)) begin
        active[i] = 1'b1;
        st[i] = cyc;
        ref_div(w, l, r, pq[i], pr[i]);
      end
      ed[i] = active[i] && (cyc + 1 == st[i] + w + 1);
      if (ed[i]) begin
        eq[i] = pq[i];
        er[i] = pr[i];
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, go32, longint'(left32), longint'(right32), 32);
    model_step(1, go4, longint'(left4), longint'(right4), 4);
    cyc++;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("done32", longint'(done32), longint'(ed[0]));
      check("quot32", longint'(q32), eq[0]);
      check("rem32",  longint'(r32), er[0]);
      check("done4",  longint'(done4), longint'(ed[1]));
      check("quot4",  longint'(q4), eq[1]);
      check("rem4",   longint'(r4), er[1]);
    end
  end

  // Drive one 32-bit op; go held until done. Returns cycles from go to done.
  task automatic op32(input logic [31:0] l, input logic [31:0] r, input bit scramble,
                      input bit keep_go, output int lat, output logic [31:0] q,
                      output logic [31:0] rm);
    @(negedge clk);
    go32 = 1'b1; left32 = l; right32 = r;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (done32 || lat >= 200) break;
      if (scramble) begin
        left32 = $urandom;
        right32 = $urandom;
      end
    end
    q = q32;
    rm = r32;
    if (!keep_go) go32 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] l, input logic [3:0] r, output int lat);
    @(negedge clk);
    go4 = 1'b1; left4 = l; right4 = r;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (done4 || lat >= 50) break;
      left4 = 4'($urandom);
      right4 = 4'($urandom);
    end
    go4 = 1'b0;
  endtask

  initial begin
    int lat, pulses;
    logic [31:0] q, rm, a, b;

    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_quot", longint'(q32), 0);
    check("reset_rem", longint'(r32), 0);
    check("reset_done", longint'(done32), 0);

    op32(32'd100, 32'd7, 1'b0, 1'b0, lat, q, rm);
    check("basic_lat", lat, 33);
    check("basic_quot", longint'(q), 14);
    check("basic_rem", longint'(rm), 2);
    @(negedge clk);
    check("basic_done_drop", longint'(done32), 0);

    op32(32'h1234, 32'd0, 1'b1, 1'b0, lat, q, rm);
    check("div0_quot", longint'(q), 64'hFFFF_FFFF);
    check("div0_rem", longint'(rm), 64'h1234);

    op32(32'hFFFF_FFFF, 32'd1, 1'b1, 1'b0, lat, q, rm);
    check("max_div1_quot", longint'(q), 64'hFFFF_FFFF);
    check("max_div1_rem", longint'(rm), 0);
    op32(32'd0, 32'd5, 1'b1, 1'b0, lat, q, rm);
    check("zero_div5_quot", longint'(q), 0);
    check("zero_div5_rem", longint'(rm), 0);
    op32(32'd5, 32'd9, 1'b1, 1'b0, lat, q, rm);
    check("small_quot", longint'(q), 0);
    check("small_rem", longint'(rm), 5);

    // Reset in cycle 10 of an op aborts it silently
    @(negedge clk);
    go32 = 1'b1; left32 = 32'd100; right32 = 32'd7;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    reset = 1'b1; go32 = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done32) pulses++;
    end
    check("abort_pulses", pulses, 0);
    check("abort_quot", longint'(q32), 0);
    check("abort_rem", longint'(r32), 0);
    op32(32'd50, 32'd5, 1'b0, 1'b0, lat, q, rm);
    check("post_reset_lat", lat, 33);
    check("post_reset_quot", longint'(q), 10);
    check("post_reset_rem", longint'(rm), 0);

    // Back-to-back: go stays high, operands change in the cycle after done
    op32(32'd1000, 32'd3, 1'b0, 1'b1, lat, q, rm);
    check("b2b_first_quot", longint'(q), 333);
    check("b2b_first_rem", longint'(rm), 1);
    @(negedge clk);
    left32 = 32'd81; right32 = 32'd9;
    lat = 1;
    forever begin
      @(negedge clk);
      lat++;
      if (done32 || lat >= 200) break;
      check("b2b_hold_quot", longint'(q32), 333);
    end
    go32 = 1'b0;
    check("b2b_gap", lat, 34);
    check("b2b_second_quot", longint'(q32), 9);
    check("b2b_second_rem", longint'(r32), 0);

    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 255));
        2:       b = a >> $urandom_range(0, 31);
        default: b = $urandom;
      endcase
      op32(a, b, 1'b1, 1'b0, lat, q, rm);
      check("rand_lat", lat, 33);
    end

    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        op4(4'(i), 4'(j), lat);
        check("w4_lat", lat, 5);
      end
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
